csr_trap_unit: RTL and testbench

//  Machine-mode CSR file plus trap/return sequencer for the 5-stage RV32I core.

---
 rtl/csr_trap_unit_pkg.sv | 44 ++++
 rtl/csr_trap_unit_csr_file.sv | 122 ++++++++++++
 rtl/csr_trap_unit.sv | 143 ++++++++++++++
 tb/tb_csr_trap_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, field positions, exception codes, CSR op codes and FSM states.
package csr_trap_unit_pkg;

  // Implemented machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  // Field positions inside the implemented CSRs
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  // mcause exception codes; the interrupt flag is the cause MSB
  localparam logic [3:0] EXC_ILLEGAL  = 4'd2;
  localparam logic [3:0] EXC_ECALL_M  = 4'd11;
  localparam logic [3:0] IRQ_MEXT     = 4'd11;

  // funct3 of the csr_type instructions
  typedef enum logic [2:0] {
    CSR_OP_NONE = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_RSV  = 3'b100,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_e;

  // Trap/return sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE     = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

endpackage

// File: rtl/csr_trap_unit_csr_file.sv
// Machine-mode CSR storage: address decode for reads, read-modify-write for
// csr_type instructions, and the field updates done on trap entry and mret.
module csr_file
  import csr_trap_unit_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     addr,
  output logic [XLEN-1:0] rdata,
  input  logic            wr_en,
  input  logic [2:0]      wr_op,
  input  logic [XLEN-1:0] wr_src,
  input  logic            wr_src0,
  input  logic            ext_irq,
  input  logic            trap_save,
  input  logic [XLEN-1:0] save_pc,
  input  logic [XLEN-1:0] save_cause,
  input  logic            mret_restore,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc,
  output logic            irq_armed
);

  localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};

  logic            mie_q;
  logic            mpie_q;
  logic            meie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;

  logic [XLEN-1:0] wdata;
  logic            do_write;
  csr_op_e         op_e;

  assign op_e      = csr_op_e'(wr_op);
  assign mtvec     = mtvec_q;
  assign mepc      = mepc_q;
  assign irq_armed = mie_q & meie_q;

  // Read mux: old CSR value for the addressed register, unimplemented read 0
  always_comb begin
    rdata = '0;
    case (addr)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE_BIT]  = mie_q;
        rdata[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE:      rdata[MIE_MEIE_BIT] = meie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MIP:      rdata[MIP_MEIP_BIT] = ext_irq;
      default:      rdata = '0;
    endcase
  end

  // New value for the RMW; set/clear forms with a zero source do not write
  always_comb begin
    wdata    = rdata;
    do_write = 1'b0;
    case (op_e)
      CSR_OP_RW, CSR_OP_RWI: begin
        wdata    = wr_src;
        do_write = wr_en;
      end
      CSR_OP_RS, CSR_OP_RSI: begin
        wdata    = rdata | wr_src;
        do_write = wr_en & ~wr_src0;
      end
      CSR_OP_RC, CSR_OP_RCI: begin
        wdata    = rdata & ~wr_src;
        do_write = wr_en & ~wr_src0;
      end
      default: begin
        wdata    = rdata;
        do_write = 1'b0;
      end
    endcase
  end

  // Register updates: trap save and mret restore take precedence over RMW writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST & ALIGN4;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (trap_save) begin
      mepc_q   <= save_pc & ALIGN4;
      mcause_q <= save_cause;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (mret_restore) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (do_write) begin
      case (addr)
        CSR_MSTATUS: begin
          mie_q  <= wdata[MSTATUS_MIE_BIT];
          mpie_q <= wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      meie_q     <= wdata[MIE_MEIE_BIT];
        CSR_MTVEC:    mtvec_q    <= wdata & ALIGN4;
        CSR_MSCRATCH: mscratch_q <= wdata;
        CSR_MEPC:     mepc_q     <= wdata & ALIGN4;
        CSR_MCAUSE:   mcause_q   <= wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file plus trap/return sequencer sitting beside EX.
// Prioritises illegal > ecall > mret > external IRQ > CSR op, then walks
// IDLE -> SAVE -> REDIRECT for traps and IDLE -> REDIRECT for mret.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_illegal,
  input  logic            ex_ecall,
  input  logic            ex_mret,
  input  logic [2:0]      ex_csr_op,
  input  logic [11:0]     ex_csr_addr,
  input  logic [XLEN-1:0] ex_csr_wsrc,
  input  logic            ex_csr_src0,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_e     state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cause_q;
  logic            redirect_q;
  logic [XLEN-1:0] target_q;

  logic            idle_live;
  logic            take_illegal;
  logic            take_ecall;
  logic            take_mret;
  logic            take_irq;
  logic            take_trap;
  logic            csr_wr_en;
  logic [XLEN-1:0] trap_cause;

  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            irq_armed;

  csr_file #(
    .XLEN      (XLEN),
    .MTVEC_RST (MTVEC_RST)
  ) u_csr_file (
    .clk          (clk),
    .rst          (rst),
    .addr         (ex_csr_addr),
    .rdata        (csr_rdata),
    .wr_en        (csr_wr_en),
    .wr_op        (ex_csr_op),
    .wr_src       (ex_csr_wsrc),
    .wr_src0      (ex_csr_src0),
    .ext_irq      (ext_irq),
    .trap_save    (state == ST_SAVE),
    .save_pc      (pc_q),
    .save_cause   (cause_q),
    .mret_restore (take_mret),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .irq_armed    (irq_armed)
  );

  // Event detection with fixed priority; only a live EX instruction in IDLE counts
  always_comb begin
    idle_live    = (state == ST_IDLE) && ex_valid;
    take_illegal = idle_live && ex_illegal;
    take_ecall   = idle_live && !ex_illegal && ex_ecall;
    take_mret    = idle_live && !ex_illegal && !ex_ecall && ex_mret;
    take_irq     = idle_live && !ex_illegal && !ex_ecall && !ex_mret
                   && irq_armed && ext_irq;
    take_trap    = take_illegal || take_ecall || take_irq;
    csr_wr_en    = idle_live && !take_trap && !take_mret;
  end

  // mcause value for the winning trap source
  always_comb begin
    trap_cause = '0;
    if (take_illegal) begin
      trap_cause[3:0] = EXC_ILLEGAL;
    end else if (take_ecall) begin
      trap_cause[3:0] = EXC_ECALL_M;
    end else begin
      trap_cause[XLEN-1] = 1'b1;
      trap_cause[3:0]    = IRQ_MEXT;
    end
  end

  // Pipeline control: detect-cycle stall/flush must be combinational so the
  // trapping instruction is killed in the same cycle it is seen
  always_comb begin
    stall          = take_trap || take_mret || (state == ST_SAVE);
    flush          = take_trap || take_mret || redirect_q;
    redirect_valid = redirect_q;
    redirect_pc    = target_q;
  end

  // Sequencer FSM; the redirect pulse and target are registered on entry to REDIRECT
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc_q       <= '0;
      cause_q    <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      redirect_q <= 1'b0;
      target_q   <= '0;
      case (state)
        ST_IDLE: begin
          if (take_trap) begin
            pc_q    <= ex_pc;
            cause_q <= trap_cause;
            state   <= ST_SAVE;
          end else if (take_mret) begin
            redirect_q <= 1'b1;
            target_q   <= mepc;
            state      <= ST_REDIRECT;
          end
        end
        ST_SAVE: begin
          // mtvec is untouched during SAVE, so sampling it here equals its REDIRECT value
          redirect_q <= 1'b1;
          target_q   <= mtvec;
          state      <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_illegal = 1'b0;
  logic        ex_ecall = 1'b0;
  logic        ex_mret = 1'b0;
  logic [2:0]  ex_csr_op = '0;
  logic [11:0] ex_csr_addr = '0;
  logic [31:0] ex_csr_wsrc = '0;
  logic        ex_csr_src0 = 1'b0;
  logic        ext_irq = 1'b0;
  logic [31:0] csr_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_trap_unit #(
    .XLEN      (32),
    .MTVEC_RST (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_illegal     (ex_illegal),
    .ex_ecall       (ex_ecall),
    .ex_mret        (ex_mret),
    .ex_csr_op      (ex_csr_op),
    .ex_csr_addr    (ex_csr_addr),
    .ex_csr_wsrc    (ex_csr_wsrc),
    .ex_csr_src0    (ex_csr_src0),
    .ext_irq        (ext_irq),
    .csr_rdata      (csr_rdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  int          pend_kind;   // 0 none, 1 trap in progress, 2 mret in progress
  int          pend_age;    // cycles since the trap was detected
  logic [31:0] pend_pc, pend_cause;

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0;
    m_mtvec = 32'h100; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
    pend_kind = 0; pend_age = 0; pend_pc = '0; pend_cause = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a, input logic irq);
    logic [31:0] r;
    r = '0;
    case (a)
      12'h300: r = (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h304: r = m_meie ? 32'h800 : 32'h0;
      12'h305: r = m_mtvec;
      12'h340: r = m_mscratch;
      12'h341: r = m_mepc;
      12'h342: r = m_mcause;
      12'h344: r = irq ? 32'h800 : 32'h0;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
      12'h304: m_meie = v[11];
      12'h305: m_mtvec = v & ~32'd3;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & ~32'd3;
      12'h342: m_mcause = v;
      default: ;
    endcase
  endtask

  // Compare process: expected outputs for this cycle, then commit the model
  // state that the coming posedge produces
  always @(negedge clk) begin
    logic [31:0] e_rd, e_rpc;
    bit e_st, e_fl, e_rv, irq;
    if (rst) begin
      m_reset();
    end else begin
      e_rd = m_read(ex_csr_addr, ext_irq);
      e_st = 0; e_fl = 0; e_rv = 0; e_rpc = '0;
      if (pend_kind == 0) begin
        if (ex_valid) begin
          irq = m_mie && m_meie && ext_irq;
          if (ex_illegal || ex_ecall || (!ex_mret && irq)) begin
            e_st = 1; e_fl = 1;
            pend_kind = 1; pend_age = 1; pend_pc = ex_pc;
            pend_cause = ex_illegal ? 32'd2 : (ex_ecall ? 32'd11 : 32'h8000_000B);
          end else if (ex_mret) begin
            e_st = 1; e_fl = 1;
            pend_kind = 2; pend_pc = m_mepc;
            m_mie = m_mpie; m_mpie = 1;
          end else if (ex_csr_op[1:0] == 2'b01) begin
            m_write(ex_csr_addr, ex_csr_wsrc);
          end else if (ex_csr_op[1:0] != 2'b00 && !ex_csr_src0) begin
            m_write(ex_csr_addr, (ex_csr_op[1:0] == 2'b10) ? (e_rd | ex_csr_wsrc)
                                                            : (e_rd & ~ex_csr_wsrc));
          end
        end
      end else if (pend_kind == 1 && pend_age == 1) begin
        e_st = 1;
        m_mepc = pend_pc & ~32'd3;
        m_mcause = pend_cause;
        m_mpie = m_mie;
        m_mie = 0;
        pend_age = 2;
      end else if (pend_kind == 1) begin
        e_fl = 1; e_rv = 1; e_rpc = m_mtvec;
        pend_kind = 0;
      end else begin
        e_fl = 1; e_rv = 1; e_rpc = pend_pc;
        pend_kind = 0;
      end
      check("model_rdata", csr_rdata, e_rd);
      check("model_stall", {31'b0, stall}, {31'b0, e_st});
      check("model_flush", {31'b0, flush}, {31'b0, e_fl});
      check("model_redirect_valid", {31'b0, redirect_valid}, {31'b0, e_rv});
      check("model_redirect_pc", redirect_pc, e_rpc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    ex_valid = 0; ex_illegal = 0; ex_ecall = 0; ex_mret = 0;
    ex_csr_op = 3'b000; ex_csr_src0 = 0; ex_csr_wsrc = '0;
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] w,
                     input logic src0);
    clr();
    ex_valid = 1; ex_csr_op = op; ex_csr_addr = a; ex_csr_wsrc = w; ex_csr_src0 = src0;
  endtask

  task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    step();
    csr(3'b000, a, '0, 1'b1);
    sample();
    check(name, csr_rdata, exp);
  endtask

  task automatic ctl_check(input string name, input bit st, input bit fl, input bit rv,
                           input logic [31:0] rpc);
    check({name, "_stall"}, {31'b0, stall}, {31'b0, st});
    check({name, "_flush"}, {31'b0, flush}, {31'b0, fl});
    check({name, "_rv"}, {31'b0, redirect_valid}, {31'b0, rv});
    check({name, "_rpc"}, redirect_pc, rpc);
  endtask

  initial begin
    clr();
    rst = 1;
    repeat (2) step();
    rst = 0;

    // Reset state
    csr(3'b000, 12'h305, '0, 1'b1);
    sample();
    check("reset_mtvec", csr_rdata, 32'h100);
    ctl_check("reset", 0, 0, 0, 32'h0);
    read_check("reset_mstatus", 12'h300, 32'h0);

    // csrrw then csrrs with zero source
    step(); csr(3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0);
    step(); csr(3'b010, 12'h340, 32'hFFFF_0000, 1'b1);
    sample();
    check("rs_src0_rdata", csr_rdata, 32'hDEAD_BEEF);
    read_check("rs_src0_unchanged", 12'h340, 32'hDEAD_BEEF);

    // Illegal instruction trap with MIE set beforehand
    step(); csr(3'b001, 12'h300, 32'h8, 1'b0);
    step(); clr(); ex_valid = 1; ex_illegal = 1; ex_pc = 32'h44;
    sample(); ctl_check("ill_c0", 1, 1, 0, 32'h0);
    step(); clr(); ex_valid = 1; ex_ecall = 1;
    sample(); ctl_check("ill_c1", 1, 0, 0, 32'h0);
    step();
    sample(); ctl_check("ill_c2", 0, 1, 1, 32'h100);
    read_check("ill_mepc", 12'h341, 32'h44);
    read_check("ill_mcause", 12'h342, 32'h2);
    read_check("ill_mstatus", 12'h300, 32'h80);

    // External interrupt pre-empting a csrrw, then mret
    step(); csr(3'b001, 12'h300, 32'h8, 1'b0);
    step(); csr(3'b001, 12'h304, 32'h800, 1'b0);
    step(); csr(3'b001, 12'h340, 32'h1234, 1'b0); ex_pc = 32'h80; ext_irq = 1;
    sample(); ctl_check("irq_c0", 1, 1, 0, 32'h0);
    step(); clr(); ext_irq = 0;
    sample(); ctl_check("irq_c1", 1, 0, 0, 32'h0);
    step();
    sample(); ctl_check("irq_c2", 0, 1, 1, 32'h100);
    read_check("irq_mcause", 12'h342, 32'h8000_000B);
    read_check("irq_mepc", 12'h341, 32'h80);
    read_check("irq_csr_dropped", 12'h340, 32'hDEAD_BEEF);
    step(); clr(); ex_valid = 1; ex_mret = 1;
    sample(); ctl_check("mret_c0", 1, 1, 0, 32'h0);
    step(); clr();
    sample(); ctl_check("mret_c1", 0, 1, 1, 32'h80);
    read_check("mret_mstatus", 12'h300, 32'h88);

    // Same-cycle illegal + ecall + IRQ
    step(); clr(); ex_valid = 1; ex_illegal = 1; ex_ecall = 1; ex_pc = 32'h90; ext_irq = 1;
    step(); clr(); ext_irq = 0;
    repeat (2) step();
    read_check("prio_ill_mcause", 12'h342, 32'h2);

    // Same-cycle ecall + csrrw
    step(); csr(3'b001, 12'h340, 32'h5, 1'b0); ex_ecall = 1; ex_pc = 32'h94;
    step(); clr();
    repeat (2) step();
    read_check("prio_ecall_mcause", 12'h342, 32'd11);
    read_check("prio_ecall_nowrite", 12'h340, 32'hDEAD_BEEF);

    // mtvec written the cycle before a trap is the redirect target
    step(); csr(3'b001, 12'h305, 32'h203, 1'b0);
    step(); clr(); ex_valid = 1; ex_ecall = 1; ex_pc = 32'hA0;
    step(); clr();
    step();
    sample(); ctl_check("mtvec_late", 0, 1, 1, 32'h200);

    // mret with MPIE=0 leaves MIE clear
    step(); clr(); ex_valid = 1; ex_mret = 1;
    step(); clr();
    sample(); ctl_check("mret2_c1", 0, 1, 1, 32'hA0);
    read_check("mret_mpie0", 12'h300, 32'h80);

    // Reset in SAVE: no redirect, CSRs back to reset values
    step(); clr(); ex_valid = 1; ex_ecall = 1; ex_pc = 32'hC0;
    step(); clr(); rst = 1;
    step(); rst = 0; ex_csr_addr = 12'h341;
    sample();
    ctl_check("rst_save", 0, 0, 0, 32'h0);
    check("rst_save_mepc", csr_rdata, 32'h0);
    read_check("rst_save_mtvec", 12'h305, 32'h100);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] addrs [8];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h7C0};
      step();
      clr();
      rst         = ($urandom_range(0, 199) == 0);
      ex_valid    = ($urandom_range(0, 9) < 8);
      ex_pc       = $urandom;
      ex_illegal  = ($urandom_range(0, 99) < 3);
      ex_ecall    = ($urandom_range(0, 99) < 3);
      ex_mret     = ($urandom_range(0, 99) < 4);
      ex_csr_op   = 3'($urandom_range(0, 7));
      ex_csr_addr = addrs[$urandom_range(0, 7)];
      ex_csr_wsrc = ($urandom_range(0, 3) == 0) ? 32'h0000_0888 : $urandom;
      ex_csr_src0 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
    end
    step();
    clr();
    rst = 0;
    ext_irq = 0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
